// File: rtl/uart_pkg.sv
// UART shared definitions: frame size, default bit period
// and receiver state encodings.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_WAIT_DIV  = 1000;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

endpackage

// File: rtl/m_uart_rx_loader_if.sv
// Byte-memory write port driven by the UART loader.
interface m_uart_rx_loader_if #(
  parameter int ADDR_W = 10
);

  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [7:0]        WDATA;

  modport master (
    output WE,
    output WADDR,
    output WDATA
  );

  modport slave (
    input WE,
    input WADDR,
    input WDATA
  );

endinterface

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM,
// VALID/FERR strobes in the stop-bit sample cycle.
module m_uart_rx
  import uart_pkg::*;
#(
  parameter int WAIT_DIV = UART_WAIT_DIV
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RXD,
  output logic [UART_DATA_BITS-1:0] DOUT,
  output logic                      VALID,
  output logic                      FERR,
  output logic                      BUSY
);

  localparam logic [31:0] HALF = 32'(WAIT_DIV / 2 - 1);
  localparam logic [31:0] FULL = 32'(WAIT_DIV - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_m;
  logic                      rx_s;
  logic [2:0]                state;
  logic [2:0]                nstate;
  logic [31:0]               cnt;
  logic [2:0]                bitn;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      last;

  assign last = (cnt == FULL);
  assign DOUT = shreg;

  always_comb begin
    nstate = state;
    VALID  = 1'b0;
    FERR   = 1'b0;
    unique case (state)
      RX_IDLE:
        if (!rx_s) nstate = RX_START;
      RX_START:
        if (cnt == HALF) nstate = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (last && bitn == LAST_BIT) nstate = RX_STOP;
      RX_STOP:
        if (last) begin
          nstate = rx_s ? RX_IDLE : RX_BREAK;
          VALID  = rx_s;
          FERR   = !rx_s;
        end
      RX_BREAK:
        if (rx_s) nstate = RX_IDLE;
      default:
        nstate = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      state <= RX_IDLE;
      BUSY  <= 1'b0;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      rx_m  <= RXD;
      rx_s  <= rx_m;
      state <= nstate;
      BUSY  <= (nstate != RX_IDLE);
      // counter restarts on every state change and every bit boundary
      if (nstate != state || last || state == RX_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 32'd1;
      if (state == RX_START) begin
        bitn <= '0;
      end else if (state == RX_DATA && last) begin
        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        bitn  <= bitn + 3'd1;
      end
    end
  end

endmodule

// File: rtl/m_uart_rx_loader.sv
// UART receive path writing each good byte to consecutive
// memory addresses, wrapping after MAX_ADDR.
module m_uart_rx_loader
  import uart_pkg::*;
#(
  parameter int WAIT_DIV = UART_WAIT_DIV,
  parameter int ADDR_W   = 10,
  parameter int MAX_ADDR = 1023
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RXD,
  m_uart_rx_loader_if.master mem,
  output logic               FERR,
  output logic               BUSY
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

  logic [UART_DATA_BITS-1:0] dout;
  logic                      valid;
  logic                      ferr_s;

  m_uart_rx #(
    .WAIT_DIV (WAIT_DIV)
  ) u_rx (
    .CLK   (CLK),
    .RST   (RST),
    .RXD   (RXD),
    .DOUT  (dout),
    .VALID (valid),
    .FERR  (ferr_s),
    .BUSY  (BUSY)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem.WE    <= 1'b0;
      mem.WADDR <= '0;
      mem.WDATA <= '0;
      FERR      <= 1'b0;
    end else begin
      mem.WE <= valid;
      FERR   <= ferr_s;
      if (valid) mem.WDATA <= dout;
      // address moves on only after the write has been presented
      if (mem.WE)
        mem.WADDR <= (mem.WADDR == LAST_ADDR) ? '0 : mem.WADDR + 1'b1;
    end
  end

endmodule

// File: tb/tb_m_uart_rx_loader.sv
// Directed bench for m_uart_rx_loader: table-driven frames
// plus hand-written glitch, break, wrap and reset sequences.
module tb_m_uart_rx_loader;

  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic ferr_a, busy_a, ferr_b, busy_b;

  m_uart_rx_loader_if #(.ADDR_W(10)) mem_a ();
  m_uart_rx_loader_if #(.ADDR_W(10)) mem_b ();

  m_uart_rx_loader #(.WAIT_DIV(WD), .ADDR_W(10), .MAX_ADDR(1023)) dut_a (
    .CLK(clk), .RST(rst), .RXD(rxd), .mem(mem_a),
    .FERR(ferr_a), .BUSY(busy_a)
  );

  m_uart_rx_loader #(.WAIT_DIV(WD), .ADDR_W(10), .MAX_ADDR(3)) dut_b (
    .CLK(clk), .RST(rst), .RXD(rxd), .mem(mem_b),
    .FERR(ferr_b), .BUSY(busy_b)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  logic [9:0] qa_addr[$];
  logic [7:0] qa_data[$];
  logic [9:0] qb_addr[$];
  logic [7:0] qb_data[$];
  int fa = 0;
  int fb = 0;
  int both = 0;

  always @(negedge clk) begin
    if (mem_a.WE) begin
      qa_addr.push_back(mem_a.WADDR);
      qa_data.push_back(mem_a.WDATA);
    end
    if (mem_b.WE) begin
      qb_addr.push_back(mem_b.WADDR);
      qb_data.push_back(mem_b.WDATA);
    end
    if (ferr_a) fa++;
    if (ferr_b) fb++;
    if ((mem_a.WE && ferr_a) || (mem_b.WE && ferr_b)) both++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
    fa = 0; fb = 0;
  endtask

  task automatic do_reset();
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (WD) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] addr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{8'h48, 10'd0};
    tbl[1]  = '{8'h65, 10'd1};
    tbl[2]  = '{8'h6C, 10'd2};
    tbl[3]  = '{8'h6C, 10'd3};
    tbl[4]  = '{8'h6F, 10'd4};
    tbl[5]  = '{8'h2C, 10'd5};
    tbl[6]  = '{8'h20, 10'd6};
    tbl[7]  = '{8'h57, 10'd7};
    tbl[8]  = '{8'h6F, 10'd8};
    tbl[9]  = '{8'h72, 10'd9};
    tbl[10] = '{8'h6C, 10'd10};
    tbl[11] = '{8'h64, 10'd11};
    tbl[12] = '{8'h21, 10'd12};

    // reset state
    do_reset();
    check("rst_we", 32'(mem_a.WE), 0);
    check("rst_waddr", 32'(mem_a.WADDR), 0);
    check("rst_wdata", 32'(mem_a.WDATA), 0);
    check("rst_ferr", 32'(ferr_a), 0);
    check("rst_busy", 32'(busy_a), 0);

    // single 'H'
    send_frame(8'h48, 1'b1);
    idle(10);
    check("t1_nwe", 32'(qa_addr.size()), 1);
    if (qa_addr.size() == 1) begin
      check("t1_addr", 32'(qa_addr[0]), 0);
      check("t1_data", 32'(qa_data[0]), 32'h48);
    end
    check("t1_waddr", 32'(mem_a.WADDR), 1);
    check("t1_ferr", 32'(fa), 0);

    // "Hello, World!" back-to-back
    do_reset();
    for (int i = 0; i < 13; i++) send_frame(tbl[i].data, 1'b1);
    idle(20);
    check("t2_nwe", 32'(qa_addr.size()), 13);
    for (int i = 0; i < 13; i++) begin
      if (i < qa_addr.size()) begin
        check($sformatf("t2_addr%0d", i), 32'(qa_addr[i]),
              32'(tbl[i].addr));
        check($sformatf("t2_data%0d", i), 32'(qa_data[i]),
              32'(tbl[i].data));
      end
    end
    check("t2_ferr", 32'(fa), 0);
    check("t2_waddr", 32'(mem_a.WADDR), 13);

    // wrap with MAX_ADDR=3
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(20);
    check("t3_nwe", 32'(qb_addr.size()), 5);
    if (qb_addr.size() == 5) begin
      check("t3_a0", 32'(qb_addr[0]), 0);
      check("t3_a1", 32'(qb_addr[1]), 1);
      check("t3_a2", 32'(qb_addr[2]), 2);
      check("t3_a3", 32'(qb_addr[3]), 3);
      check("t3_a4", 32'(qb_addr[4]), 0);
      check("t3_d4", 32'(qb_data[4]), 5);
    end
    check("t3_waddr", 32'(mem_b.WADDR), 1);
    check("t3_wdata", 32'(mem_b.WDATA), 5);

    // short glitch rejected
    do_reset();
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    idle(20);
    check("t4_busy", 32'(busy_a), 0);
    check("t4_nwe", 32'(qa_addr.size()), 0);
    check("t4_ferr", 32'(fa), 0);
    send_frame(8'hA5, 1'b1);
    idle(10);
    check("t4_nwe2", 32'(qa_addr.size()), 1);
    if (qa_addr.size() == 1) begin
      check("t4_addr", 32'(qa_addr[0]), 0);
      check("t4_data", 32'(qa_data[0]), 32'hA5);
    end

    // framing error then break
    do_reset();
    send_frame(8'h55, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t5_ferr", 32'(fa), 1);
    check("t5_nwe", 32'(qa_addr.size()), 0);
    check("t5_waddr", 32'(mem_a.WADDR), 0);
    check("t5_busy_hi", 32'(busy_a), 1);
    idle(5);
    check("t5_busy_lo", 32'(busy_a), 0);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("t5_nwe2", 32'(qa_addr.size()), 1);
    if (qa_addr.size() == 1) begin
      check("t5_addr", 32'(qa_addr[0]), 0);
      check("t5_data", 32'(qa_data[0]), 32'h3C);
    end
    check("t5_ferr2", 32'(fa), 1);

    // reset mid-frame during bit 4
    do_reset();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (WD / 2) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy_a), 0);
    check("t6_waddr", 32'(mem_a.WADDR), 0);
    idle(WD * 6);
    check("t6_nwe", 32'(qa_addr.size()), 0);
    check("t6_ferr", 32'(fa), 0);
    send_frame(8'h0F, 1'b1);
    idle(10);
    check("t6_nwe2", 32'(qa_addr.size()), 1);
    if (qa_addr.size() == 1) begin
      check("t6_addr", 32'(qa_addr[0]), 0);
      check("t6_data", 32'(qa_data[0]), 32'h0F);
    end

    check("we_ferr_overlap", 32'(both), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/m_uart_rx_loader.md
Name: m_uart_rx_loader

Overview:
UART receive path that fills the on-chip byte memory, acting as the upstream producer for the memory's write port (WE/WADDR/WDATA).
- Deserialises 8N1 frames from the RXD pin.
- Writes each good byte to consecutive memory addresses, wrapping at MAX_ADDR.
- Flags framing errors.
- Shares the bit-period convention of the transmitter: WAIT_DIV clocks per bit.

Parameters:
WAIT_DIV, 1000, clock cycles per UART bit (100 MHz / 1000 = 100 kbaud); must be >= 4.
ADDR_W, 10, memory address width.
MAX_ADDR, 1023, last address written before WADDR wraps to 0; must be < 2**ADDR_W.

Ports:
CLK  input  1  clock (100 MHz)
RST  input  1  reset, synchronous, active-high
RXD  input  1  serial receive line, asynchronous to CLK, idle high
WE  output  1  memory write enable, one-cycle pulse per good byte
WADDR  output  ADDR_W  memory write address
WDATA  output  8  memory write data
FERR  output  1  one-cycle pulse when a stop bit is sampled low
BUSY  output  1  high while a frame is being received (FSM not IDLE)

Behaviour:
Reset
- One clock; RST is synchronous and active-high.
- Reset values: WE=0, WADDR=0, WDATA=0, FERR=0, BUSY=0, FSM=IDLE, synchroniser FFs=1, bit counter=0, cycle counter=0.
- RST asserted mid-frame discards the partial byte. No WE/FERR is issued for it.

Input synchronisation
- RXD passes through a 2-FF synchroniser; rx_s denotes the second FF.
- Internal latency is 2 cycles and is not visible at any port except as timing.

Receiver FSM (cycle counter cnt, 32-bit; bit index 0..7)
- IDLE: rx_s==0 -> START, cnt=0. Otherwise stay.
- START: cnt counts to WAIT_DIV/2-1 (integer divide). At that cycle:
  - rx_s==0 -> DATA, cnt=0, bit=0.
  - rx_s==1 -> IDLE (glitch rejected; no pulse).
- DATA: at cnt==WAIT_DIV-1, shift rx_s into the byte LSB-first and set cnt=0. After bit 7 is sampled -> STOP.
- STOP: at cnt==WAIT_DIV-1:
  - rx_s==1 -> good byte, go to IDLE.
  - rx_s==0 -> framing error, go to BREAK.
- BREAK: wait for rx_s==1 -> IDLE. This prevents a held-low line (break) from being misread as a new start bit.
- BUSY = (state != IDLE), registered alongside the state.

Write interface
- Outputs are registered. In the cycle after the stop-bit sample:
  - good byte: WE=1, WDATA=byte, WADDR=current address.
  - framing error: FERR=1 and WE stays 0.
- WE and FERR are high for exactly one cycle. They are never high together.
- WADDR advances on the cycle after the WE pulse: WADDR==MAX_ADDR -> 0, else +1.
  - WADDR therefore always points at the slot for the next byte.
- WDATA holds its value until the next good byte.
- No backpressure: the memory port accepts a write every cycle.

Timing
- The earliest next start bit is detected in the cycle after return to IDLE.
- Back-to-back frames with a 1-bit stop are received without loss.

Decomposition:
- Shared package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP, BREAK);
  - localparam UART_DATA_BITS=8;
  - WAIT_DIV default constant, shared with the transmitter.
- One sub-module, m_uart_rx:
  - synchroniser plus FSM;
  - outputs DOUT[7:0], VALID pulse, FERR pulse, BUSY.
- m_uart_rx_loader instantiates m_uart_rx and adds the address counter and write-port registers.

Test Plan (WAIT_DIV=16 for simulation):
1. Reset, then serialise 0x48 ('H') with 1 stop bit -> single WE pulse, WDATA=0x48, WADDR=0 during the pulse, WADDR=1 afterwards, FERR never high.
2. Send 13 bytes "Hello, World!" back-to-back -> 13 WE pulses, addresses 0..12, WDATA matching each ASCII code, no FERR.
3. MAX_ADDR=3, send 5 bytes 0x01..0x05 -> writes at addresses 0,1,2,3,0. Final WADDR=1, and the fifth WDATA=0x05.
4. Pull RXD low for 4 clocks (shorter than WAIT_DIV/2), then return high -> no WE, no FERR, BUSY returns to 0 and the next valid frame 0xA5 is received correctly at WADDR=0.
5. Send 0x55 with the stop bit driven 0, holding low for 40 cycles -> one FERR pulse, no WE, WADDR unchanged. BUSY stays high until RXD returns high, then frame 0x3C is received correctly.
6. Assert RST during data bit 4 of frame 0xFF -> no WE, WADDR=0, BUSY=0 the cycle after RST. A following frame 0x0F is written at address 0.
